etapa_fetch: RTL and testbench
==============================

// Module: etapa_fetch
// PURPOSE
//  Instruction-fetch stage directly upstream of the single-cycle datapath: holds the PC and a
//  word-addressed instruction memory, and registers the 32-bit instruction word that drives the
//  datapath's Instruccion input. Supports program load, stall, branch/jump redirect and halt.
// PARAMETERS
//  ADDR_W     5              log2 of instruction-memory depth in words (default 32 words)
//  RESET_PC   32'h0000_0000  PC value after reset
//  HALT_WORD  32'hFFFF_FFFF  fetched word that halts the stage
// PORTS
//  clk          in   1       rising-edge clock
//  rst_n        in   1       asynchronous active-low reset
//  start        in   1       one-cycle pulse: leave IDLE and begin fetching
//  stall        in   1       hold the current instruction and PC
//  redirect_en  in   1       load PC from redirect_pc (branch/jump)
//  redirect_pc  in   32      target byte address; bits [1:0] ignored
//  prog_we      in   1       program-memory write strobe, honoured in IDLE only
//  prog_addr    in   ADDR_W  program-memory word address
//  prog_data    in   32      program-memory write data
//  instruccion  out  32      registered instruction to the datapath
//  inst_valid   out  1       instruccion holds a real fetched word
//  pc_out       out  32      byte address of the word in instruccion
//  pc_plus4     out  32      pc_out + 4 (combinational)
//  halted       out  1       HALT_WORD reached
//  busy         out  1       state is FETCH or STALL
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instruccion=0, inst_valid=0, pc_out=0,
//   halted=0. Memory contents are not reset.
//  States: IDLE, FETCH, STALL, HALT.
//  IDLE:  prog_we=1 writes mem[prog_addr]<=prog_data. start=1 -> FETCH. Outputs hold.
//   start and prog_we in the same cycle: the write completes, and the first fetch sees it.
//  FETCH (stall=0, redirect_en=0): each cycle instruccion<=mem[pc[ADDR_W+1:2]], pc_out<=pc,
//   inst_valid<=1, pc<=pc+4. Latency: the word at PC appears on instruccion 1 cycle later.
//  Stall: in FETCH, stall=1 -> STALL. instruccion, pc_out, inst_valid and pc hold.
//   In STALL, stall=0 -> FETCH, and the fetch resumes at the held pc.
//  Redirect: redirect_en has priority over stall, in FETCH or STALL. Effects:
//   pc<={redirect_pc[31:2],2'b00}; instruccion<=0; inst_valid<=0 (one bubble);
//   the state becomes FETCH. The target word appears on the following cycle.
//  Halt: a fetched word equal to HALT_WORD is not issued. Instead instruccion<=0,
//   inst_valid<=0, halted<=1, pc holds the halt address, and the state becomes HALT.
//   HALT is left only by reset. start, stall, redirect_en and prog_we are ignored in HALT.
//  prog_we outside IDLE is ignored, and memory is unchanged.
//  Arithmetic: pc+4 wraps modulo 2^32. The memory index uses pc[ADDR_W+1:2], so higher
//   address bits alias. No error is flagged.
//  instruccion=0 is the bubble/NOP word, and downstream write enables treat it as harmless.
//  Reset asserted mid-fetch aborts immediately to the reset values. A pending stall or
//   redirect is discarded.
// TESTING
//  1 Load mem[0..3]=11,22,33,44 in IDLE, then pulse start -> 1 cycle later instruccion=11,
//    pc_out=0, inst_valid=1; then 22, 33, 44 on consecutive cycles with pc_out=4, 8, 12.
//  2 stall=1 for 3 cycles while instruccion=22 -> instruccion=22 and pc_out=4 held for 3 cycles;
//    after release, 33 follows next cycle.
//  3 redirect_en=1 with redirect_pc=32'h0000_0006 while stall=1 -> next cycle inst_valid=0 and
//    instruccion=0; the cycle after, instruccion=mem[1], pc_out=4.
//  4 mem[2]=HALT_WORD -> after mem[1] issues, inst_valid=0 and halted=1; pc_out stays at the last
//    valid word; start and redirect_en have no effect.
//  5 ADDR_W=5, redirect to 32'h0000_0080 -> fetches mem[0] (alias). Redirect to 32'hFFFF_FFFC,
//    then next PC -> 0 (wrap).
//  6 prog_we during FETCH leaves memory unchanged. rst_n pulled low mid-stream -> all outputs
//    zero immediately, and state is IDLE.

Source files
------------

// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: PC, word-addressed program memory and the
// registered instruction word feeding the single-cycle datapath.
module etapa_fetch #(
  parameter int unsigned ADDR_W    = 5,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [31:0]       redirect_pc,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_data,
  output logic [31:0]       instruccion,
  output logic              inst_valid,
  output logic [31:0]       pc_out,
  output logic [31:0]       pc_plus4,
  output logic              halted,
  output logic              busy
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_STALL = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pco_q, pco_d;
  logic        valid_q, valid_d;
  logic        halt_q, halt_d;

  logic [31:0] mem_q [DEPTH];
  logic [31:0] word;
  logic        mem_we;
  logic        unused_rpc;

  // Higher PC bits alias onto the small memory.
  assign word       = mem_q[pc_q[ADDR_W+1:2]];
  assign mem_we     = (state_q == S_IDLE) && prog_we;
  assign unused_rpc = ^redirect_pc[1:0];

  // Program memory keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pco_d   = pco_q;
    valid_d = valid_q;
    halt_d  = halt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH, S_STALL: begin
        if (redirect_en) begin
          pc_d    = {redirect_pc[31:2], 2'b00};
          instr_d = '0;
          valid_d = 1'b0;
          state_d = S_FETCH;
        end else if (stall) begin
          state_d = S_STALL;
        end else if (word == HALT_WORD) begin
          instr_d = '0;
          valid_d = 1'b0;
          halt_d  = 1'b1;
          state_d = S_HALT;
        end else begin
          instr_d = word;
          pco_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pco_q   <= '0;
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      valid_q <= valid_d;
      halt_q  <= halt_d;
    end
  end

  assign instruccion = instr_q;
  assign inst_valid  = valid_q;
  assign pc_out      = pco_q;
  assign pc_plus4    = pco_q + 32'd4;
  assign halted      = halt_q;
  assign busy        = (state_q == S_FETCH) || (state_q == S_STALL);

endmodule

// File: tb/tb_etapa_fetch.sv
// Bench for etapa_fetch: directed vector table, hand sequences for
// reset/alias/wrap, then random stimulus against a behavioural model.
module tb_etapa_fetch;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [31:0] prog_data;
  logic [31:0] instruccion;
  logic        inst_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        busy;

  etapa_fetch #(
    .ADDR_W(5),
    .RESET_PC(32'h0000_0000),
    .HALT_WORD(HALT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stall(stall),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_data(prog_data),
    .instruccion(instruccion),
    .inst_valid(inst_valid),
    .pc_out(pc_out),
    .pc_plus4(pc_plus4),
    .halted(halted),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  typedef struct {
    bit          st;
    bit          stl;
    bit          rd;
    logic [31:0] rpc;
    bit          we;
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] ei;
    bit          ev;
    logic [31:0] ep;
    bit          eh;
    bit          eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit st, bit stl, bit rd, logic [31:0] rpc,
                             bit we, logic [4:0] a, logic [31:0] d,
                             logic [31:0] ei, bit ev, logic [31:0] ep,
                             bit eh, bit eb);
    vec_t r;
    r.st = st; r.stl = stl; r.rd = rd; r.rpc = rpc;
    r.we = we; r.a = a; r.d = d;
    r.ei = ei; r.ev = ev; r.ep = ep; r.eh = eh; r.eb = eb;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string t, logic [31:0] ei, logic ev,
                         logic [31:0] ep, logic eh, logic eb);
    chk({t, ".instr"}, instruccion, ei);
    chk({t, ".valid"}, 32'(inst_valid), 32'(ev));
    chk({t, ".pc_out"}, pc_out, ep);
    chk({t, ".pc_plus4"}, pc_plus4, ep + 32'd4);
    chk({t, ".halted"}, 32'(halted), 32'(eh));
    chk({t, ".busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic idle_in();
    start = 0; stall = 0; redirect_en = 0; redirect_pc = 0;
    prog_we = 0; prog_addr = 0; prog_data = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: running vs. stalled only matters for busy,
  // so it keeps a single "running" mode.
  typedef enum int {M_IDLE, M_RUN, M_HALT} mode_t;
  mode_t       m_mode;
  logic [31:0] m_mem [32];
  logic [31:0] m_pc, m_ins, m_pco;
  bit          m_v, m_h;

  task automatic model_reset();
    m_mode = M_IDLE; m_pc = 0; m_ins = 0; m_pco = 0; m_v = 0; m_h = 0;
  endtask

  task automatic model_step();
    logic [31:0] w;
    case (m_mode)
      M_IDLE: begin
        if (prog_we) m_mem[prog_addr] = prog_data;
        if (start) m_mode = M_RUN;
      end
      M_RUN: begin
        if (redirect_en) begin
          m_pc = redirect_pc & ~32'd3;
          m_ins = 0;
          m_v = 0;
        end else if (!stall) begin
          w = m_mem[(m_pc / 4) % 32];
          if (w == HALT) begin
            m_ins = 0; m_v = 0; m_h = 1; m_mode = M_HALT;
          end else begin
            m_ins = w; m_pco = m_pc; m_v = 1; m_pc = m_pc + 4;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic rnd_inputs(bit allow_start);
    start = allow_start && ($urandom % 5 == 0);
    stall = ($urandom % 4 == 0);
    redirect_en = ($urandom % 8 == 0);
    redirect_pc = ($urandom % 4 == 0) ? $urandom : ($urandom & 32'hFF);
    prog_we = ($urandom % 3 == 0);
    prog_addr = 5'($urandom);
    prog_data = ($urandom % 6 == 0) ? HALT : $urandom;
  endtask

  task automatic rnd_reset();
    idle_in();
    rst_n = 0;
    model_reset();
    #1;
    chk_all("rnd_rst", m_ins, m_v, m_pco, m_h, m_mode == M_RUN);
    tick();
    rst_n = 1;
  endtask

  initial begin
    idle_in();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    chk_all("reset", 0, 0, 0, 0, 0);

    tbl.push_back(v(0,0,0,0, 1,0,32'd11, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 1,1,32'd22, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 1,2,32'd33, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 1,4,32'd55, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 1,5,32'd66, 0,0,0,0,0));
    tbl.push_back(v(0,0,0,0, 1,6,HALT,   0,0,0,0,0));
    tbl.push_back(v(1,0,0,0, 1,3,32'd44, 0,0,0,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0, 32'd11,1,32'd0,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0, 32'd22,1,32'd4,0,1));
    tbl.push_back(v(0,1,0,0, 0,0,0, 32'd22,1,32'd4,0,1));
    tbl.push_back(v(0,1,0,0, 0,0,0, 32'd22,1,32'd4,0,1));
    tbl.push_back(v(0,1,0,0, 0,0,0, 32'd22,1,32'd4,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0, 32'd33,1,32'd8,0,1));
    tbl.push_back(v(0,0,0,0, 1,5,32'h1234, 32'd44,1,32'd12,0,1));
    tbl.push_back(v(0,1,1,32'h6, 0,0,0, 0,0,32'd12,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0, 32'd22,1,32'd4,0,1));
    tbl.push_back(v(0,0,1,32'h14, 0,0,0, 0,0,32'd4,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0, 32'd66,1,32'h14,0,1));
    tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,32'h14,1,0));
    tbl.push_back(v(1,1,1,0, 1,0,32'd99, 0,0,32'h14,1,0));
    tbl.push_back(v(0,0,0,0, 0,0,0, 0,0,32'h14,1,0));

    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].st; stall = tbl[i].stl;
      redirect_en = tbl[i].rd; redirect_pc = tbl[i].rpc;
      prog_we = tbl[i].we; prog_addr = tbl[i].a; prog_data = tbl[i].d;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].ei, tbl[i].ev, tbl[i].ep,
              tbl[i].eh, tbl[i].eb);
    end

    // Mid-stream async reset; memory must survive it.
    idle_in();
    rst_n = 0;
    tick();
    rst_n = 1;
    chk_all("rst2", 0, 0, 0, 0, 0);
    start = 1;
    tick();
    start = 0;
    chk_all("rst2.start", 0, 0, 0, 0, 1);
    tick();
    chk_all("rst2.f0", 32'd11, 1, 32'd0, 0, 1);
    tick();
    chk_all("rst2.f1", 32'd22, 1, 32'd4, 0, 1);
    stall = 1;
    redirect_en = 1;
    redirect_pc = 32'h40;
    #2;
    rst_n = 0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0);
    tick();
    idle_in();
    rst_n = 1;
    tick();
    chk_all("post_rst", 0, 0, 0, 0, 0);

    // Address aliasing and PC wrap.
    prog_we = 1; prog_addr = 5'd31; prog_data = 32'h31;
    tick();
    chk_all("alias.ld", 0, 0, 0, 0, 0);
    prog_we = 0; start = 1;
    tick();
    start = 0;
    chk_all("alias.start", 0, 0, 0, 0, 1);
    tick();
    chk_all("alias.f0", 32'd11, 1, 32'd0, 0, 1);
    redirect_en = 1; redirect_pc = 32'h80;
    tick();
    redirect_en = 0;
    chk_all("alias.bub", 0, 0, 32'd0, 0, 1);
    tick();
    chk_all("alias.f80", 32'd11, 1, 32'h80, 0, 1);
    redirect_en = 1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_en = 0;
    chk_all("wrap.bub", 0, 0, 32'h80, 0, 1);
    tick();
    chk_all("wrap.top", 32'h31, 1, 32'hFFFF_FFFC, 0, 1);
    tick();
    chk_all("wrap.zero", 32'd11, 1, 32'd0, 0, 1);

    // Random phase against the model.
    rnd_reset();
    for (int i = 0; i < 32; i++) begin
      idle_in();
      prog_we = 1;
      prog_addr = 5'(i);
      prog_data = ($urandom % 6 == 0) ? HALT : $urandom;
      model_step();
      tick();
      chk_all("rnd.fill", m_ins, m_v, m_pco, m_h, m_mode == M_RUN);
    end
    for (int e = 0; e < 20; e++) begin
      if (e != 0) rnd_reset();
      for (int c = 0; c < 60; c++) begin
        rnd_inputs(1'b1);
        model_step();
        tick();
        chk_all($sformatf("rnd%0d.%0d", e, c), m_ins, m_v, m_pco, m_h,
                m_mode == M_RUN);
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
